// File: rtl/calc_dsp_check_if.sv
// Observation bundle for calc_dsp_check: run status flags and the DSP-path accumulator.
interface calc_dsp_check_if;
  logic        correct;
  logic        done;
  logic [31:0] acc;

  modport master (output correct, done, acc);
  modport slave  (input  correct, done, acc);
endinterface

// File: rtl/calc_dsp_check.sv
// Self-checking MAC: a pipelined multiply/accumulate path is cross-checked against a
// bit-serial shift-add reference over a fixed operand sequence.
module calc_dsp_check #(
  parameter int unsigned N_OPS    = 256,
  parameter logic [15:0] FAULT_OP = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  calc_dsp_check_if.master res
);

  typedef enum logic [1:0] {LOAD, MUL, CHECK, DONE} state_e;

  localparam logic [15:0] LAST_IDX = 16'(N_OPS - 1);
  localparam bit          FAULT_EN = (32'(FAULT_OP) < N_OPS);

  state_e      state_q, state_d;
  logic [15:0] idx_q;
  logic [3:0]  cnt_q;
  logic [15:0] a_q, b_q;
  logic        v1_q, v2_q;
  logic [31:0] prod_q;
  logic [31:0] ser_q;
  logic [31:0] acc_dsp_q;
  logic [31:0] acc_ref_q, acc_ref_d;
  logic        mism_q;
  logic        mism_now;
  logic        done_q, correct_q;
  logic        last;
  logic        fault_now;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    last      = (idx_q == LAST_IDX);
    acc_ref_d = acc_ref_q + ser_q;
    mism_now  = (prod_q != ser_q) || (acc_dsp_q != acc_ref_d);
    fault_now = FAULT_EN && (idx_q == FAULT_OP);
    unique case (state_q)
      LOAD:    state_d = MUL;
      MUL:     if (cnt_q == 4'd15) state_d = CHECK;
      CHECK:   state_d = last ? DONE : LOAD;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      prod_q    <= '0;
      ser_q     <= '0;
      acc_dsp_q <= '0;
      acc_ref_q <= '0;
      mism_q    <= 1'b0;
      done_q    <= 1'b0;
      correct_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // DSP path: operands -> product -> accumulate, one valid token per operand pair
      v1_q <= (state_q == LOAD);
      v2_q <= v1_q;
      if (v1_q) prod_q <= ({16'b0, a_q} * {16'b0, b_q}) ^ {31'b0, fault_now};
      if (v2_q) acc_dsp_q <= acc_dsp_q + prod_q;

      unique case (state_q)
        LOAD: begin
          a_q   <= 16'h1234 + idx_q * 16'h0101;
          b_q   <= 16'hFEDC - idx_q * 16'h0011;
          ser_q <= '0;
          cnt_q <= '0;
        end
        MUL: begin
          if (b_q[cnt_q]) ser_q <= ser_q + ({16'b0, a_q} << cnt_q);
          cnt_q <= cnt_q + 4'd1;
        end
        CHECK: begin
          acc_ref_q <= acc_ref_d;
          mism_q    <= mism_q | mism_now;
          if (last) begin
            done_q    <= 1'b1;
            correct_q <= ~(mism_q | mism_now);
          end else begin
            idx_q <= idx_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res.correct = correct_q;
  assign res.done    = done_q;
  assign res.acc     = acc_dsp_q;

endmodule

// File: tb/tb_calc_dsp_check.sv
// Bench for calc_dsp_check: four parameterisations run in parallel; expected final
// accumulators go to a scoreboard at run start and are popped when each instance finishes.
module tb_calc_dsp_check;

  typedef struct {
    int          inst;
    logic [31:0] acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_dsp_check_if if_def ();
  calc_dsp_check_if if_one ();
  calc_dsp_check_if if_two ();
  calc_dsp_check_if if_flt ();

  calc_dsp_check u_def (.clk(clk), .rst(rst), .res(if_def));
  calc_dsp_check #(.N_OPS(1))         u_one (.clk(clk), .rst(rst), .res(if_one));
  calc_dsp_check #(.N_OPS(2))         u_two (.clk(clk), .rst(rst), .res(if_two));
  calc_dsp_check #(.FAULT_OP(16'd5))  u_flt (.clk(clk), .rst(rst), .res(if_flt));

  logic        done_v    [4];
  logic        correct_v [4];
  logic [31:0] acc_v     [4];
  assign done_v[0] = if_def.done;  assign correct_v[0] = if_def.correct;  assign acc_v[0] = if_def.acc;
  assign done_v[1] = if_one.done;  assign correct_v[1] = if_one.correct;  assign acc_v[1] = if_one.acc;
  assign done_v[2] = if_two.done;  assign correct_v[2] = if_two.correct;  assign acc_v[2] = if_two.acc;
  assign done_v[3] = if_flt.done;  assign correct_v[3] = if_flt.correct;  assign acc_v[3] = if_flt.acc;

  localparam int    FIN    [4] = '{18 * 256, 18 * 1, 18 * 2, 18 * 256};
  localparam bit    EXP_OK [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam string NAME   [4] = '{"def", "one", "two", "flt"};

  int          n_checks = 0;
  int          n_errors = 0;
  int          ed       = 0;
  sb_t         sb_q[$];
  logic [31:0] held_acc [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ed);
    end
  endtask

  function automatic logic [31:0] model_acc(input int n, input int fault_op);
    logic [15:0] a, b;
    logic [31:0] p;
    logic [31:0] acc = '0;
    for (int i = 0; i < n; i++) begin
      a = 16'h1234 + 16'(i) * 16'h0101;
      b = 16'hFEDC - 16'(i) * 16'h0011;
      p = {16'b0, a} * {16'b0, b};
      if (i == fault_op) p[0] = ~p[0];
      acc = acc + p;
    end
    return acc;
  endfunction

  // Called when rst is released: discard stale expectations, push fresh ones in finish order.
  task automatic start_run();
    sb_q.delete();
    ed = 0;
    sb_q.push_back('{1, 32'h121F3CB0});
    sb_q.push_back('{2, 32'h121F3CB0 + {16'b0, 16'h1335} * {16'b0, 16'hFECB}});
    sb_q.push_back('{0, model_acc(256, -1)});
    sb_q.push_back('{3, model_acc(256, 5)});
  endtask

  task automatic step();
    logic rst_at_edge;
    sb_t  e;
    bit   exp_done;
    @(posedge clk);
    rst_at_edge = rst;
    #1;
    if (rst_at_edge) begin
      ed = 0;
      for (int k = 0; k < 4; k++)
        check($sformatf("rst_%s", NAME[k]),
              {acc_v[k], 30'b0, done_v[k], correct_v[k]} == '0 ? 32'd0 : 32'd1, 32'd0);
    end else begin
      ed++;
      for (int k = 0; k < 4; k++) begin
        exp_done = (ed >= FIN[k]);
        check($sformatf("done_%s", NAME[k]), {31'b0, done_v[k]}, {31'b0, exp_done});
        check($sformatf("correct_%s", NAME[k]), {31'b0, correct_v[k]},
              {31'b0, exp_done & EXP_OK[k]});
        if (ed == FIN[k]) begin
          if (sb_q.size() == 0) begin
            check($sformatf("sb_empty_%s", NAME[k]), 32'd0, 32'd1);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("sb_order_%s", NAME[k]), k, e.inst);
            check($sformatf("acc_%s", NAME[k]), acc_v[k], e.acc);
            held_acc[k] = e.acc;
          end
        end else if (ed > FIN[k]) begin
          check($sformatf("acc_hold_%s", NAME[k]), acc_v[k], held_acc[k]);
        end
      end
    end
  endtask

  initial begin
    // Hold reset for 50 cycles: all outputs must stay at zero.
    rst = 1'b1;
    repeat (50) step();

    // Full run with every instance to completion, then a few held cycles.
    rst = 1'b0;
    start_run();
    repeat (4608 + 20) step();
    check("sb_drained", sb_q.size(), 0);

    // Fresh run interrupted by a one-cycle reset on its 1000th edge.
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_run();
    repeat (999) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_run();
    repeat (4608 + 5) step();
    check("sb_drained_mid", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_dsp_check.md
Name: calc_dsp_check

Overview:
Self-checking multiply-accumulate block. It generates a fixed operand sequence internally and computes a*b two ways: a pipelined DSP-style path (registered multiplier plus accumulator) and a bit-serial shift-add reference path. The two results are compared for every operand pair. The block reports a single pass flag that top-level logic drives onto the board LEDs (inverted there, because the LEDs are active low).

Parameters:
N_OPS, 256, number of operand pairs processed per run (1..65535).
FAULT_OP, 16'hFFFF, operand index at which bit 0 of the DSP-path product is inverted; a value of N_OPS or above disables fault injection.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
correct  output  1  high only when the run has finished with zero mismatches.
done  output  1  high when the run has finished, whether it passed or failed.
acc  output  32  DSP-path accumulator value (for observation).

Behaviour:
- Reset (rst=1 at an edge):
  - state=LOAD, index i=0, both accumulators=0, mismatch flag=0.
  - correct=0, done=0, acc=0.
- Operands for index i (16-bit, wrap modulo 2^16):
  - a_i = 16'h1234 + i*16'h0101
  - b_i = 16'hFEDC - i*16'h0011
- FSM states: LOAD, MUL, CHECK, DONE.
  - LOAD (1 cycle): latch a_i and b_i into the operand registers of both paths; clear the serial product register; go to MUL.
  - MUL (exactly 16 cycles, counter 0..15):
    - Reference path: each cycle, if multiplier bit k is set, add (a << k) to a 32-bit partial product.
    - DSP path, 3-stage pipeline started at LOAD:
      - stage 1 = registered operands
      - stage 2 = registered 32-bit product
      - stage 3 = accumulator, acc_dsp += product
    - The DSP-path result is valid well before MUL ends.
  - CHECK (1 cycle):
    - acc_ref += serial product.
    - Compare the DSP product with the serial product, and acc_dsp with the new acc_ref. Any difference sets the sticky mismatch flag.
    - If i == N_OPS-1, go to DONE; otherwise i++ and go to LOAD.
  - DONE: hold all state; done=1; correct = ~mismatch. Leave DONE only via rst.
- Accumulators:
  - 32-bit unsigned, wrap on overflow; no saturation.
- Products:
  - 16x16 unsigned, full 32-bit result, no truncation.
- Timing: each operand takes 18 cycles. done and correct are registered and rise on the 18*N_OPS-th rising edge after the first edge with rst=0. With the default, that is edge 4608.
- Reset mid-run: any state returns to LOAD with i=0 on the next edge; partial results are discarded.
- rst held high: outputs stay at their reset values.
- Fault injection: when i == FAULT_OP and FAULT_OP < N_OPS, bit 0 of the stage-2 product is inverted before the accumulate and compare.
- correct and done never glitch high before DONE.

Test Plan:
- Reset with default parameters, then 4608 edges with rst=0 -> done=0 and correct=0 through edge 4607; both =1 from edge 4608 onward and held.
- N_OPS=1 -> after 18 edges, acc=32'h121F3CB0 (0x1234*0xFEDC), done=1, correct=1.
- N_OPS=2 -> acc = 32'h121F3CB0 + (16'h1335*16'hFECB) mod 2^32; correct=1 after 36 edges.
- FAULT_OP=5, default N_OPS -> done=1 at edge 4608, correct=0 and stays 0.
- Assert rst for one cycle at edge 1000 of a run -> done/correct stay 0; they rise exactly 4608 edges after rst deasserts.
- Hold rst=1 for 50 cycles -> correct=0, done=0, acc=0 throughout.
